// File: rtl/cnt_pkg.sv
// Shared definitions for the counter family (cnt_down, tick_gen and the
// up-counter tops).
//   - state_t and the IDLE / RUN / PAUSED state codes
//   - CNT_W, DIV_W : default widths of the count value and the prescaler
package cnt_pkg;

  localparam int CNT_W = 6;
  localparam int DIV_W = 32;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t RUN    = 2'd1;
  localparam state_t PAUSED = 2'd2;

endpackage : cnt_pkg

// File: rtl/cnt_down_tick_gen.sv
// tick_gen: programmable prescaler producing one count tick every N enabled
// clock cycles, where N = max(num, 1).
// Ports:
//   clk  in          rising-edge clock
//   rst  in          synchronous active-high reset, clears the prescaler
//   clr  in          synchronous clear of the prescaler (wins over en)
//   en   in          advance the prescaler this cycle; hold when low
//   num  in  DIV_W   clk cycles per tick; 0 behaves like 1
//   tick out         high in the enabled cycle where the prescaler is at N-1
module tick_gen #(
  parameter int DIV_W = cnt_pkg::DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] num,
  output logic             tick
);
  import cnt_pkg::*;

  logic [DIV_W-1:0] pre;
  logic [DIV_W-1:0] period;
  logic [DIV_W-1:0] last;

  // num = 0 is treated as a divide-by-one so the tick never stalls.
  assign period = (num == '0) ? DIV_W'(1) : num;
  assign last   = period - DIV_W'(1);

  // tick is decoded from the current prescaler value so the consumer acts on
  // the same edge at which the prescaler wraps back to 0.
  assign tick = en && (pre == last);

  // If num drops below the running prescaler value, pre simply keeps
  // counting up and wraps through 2^DIV_W before matching again.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pre <= '0;
    end else if (en) begin
      pre <= tick ? '0 : pre + DIV_W'(1);
    end
  end

endmodule : tick_gen

// File: rtl/cnt_down.sv
// cnt_down: loadable countdown timer with run/pause control and optional
// auto-reload.
// Ports:
//   clk       in          rising-edge clock
//   rst       in          synchronous active-high reset
//   num       in  DIV_W   clk cycles per count tick (0 and 1: every cycle)
//   load      in          load load_val into count and reload registers
//   load_val  in  CNT_W   value to load
//   start     in          begin counting (IDLE) or resume (PAUSED)
//   pause     in          suspend counting (RUN only)
//   auto      in          on expiry, keep running and reload instead of stopping
//   out       out CNT_W   current count (registered)
//   running   out         high while in RUN (registered)
//   done      out         one-cycle pulse when the count reaches 0 (registered)
// Control priority at each edge: rst > load > pause > start.
module cnt_down #(
  parameter int CNT_W = cnt_pkg::CNT_W,
  parameter int DIV_W = cnt_pkg::DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] num,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             auto,
  output logic [CNT_W-1:0] out,
  output logic             running,
  output logic             done
);
  import cnt_pkg::*;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] reload;
  logic [CNT_W-1:0] out_nxt;
  logic [CNT_W-1:0] reload_nxt;
  logic             done_nxt;
  logic             tick;
  logic             pre_clr;
  logic             pre_en;
  logic             start_idle;

  // Next count value on a tick: 0 re-enters the reload value (auto mode),
  // anything else steps down by one. Never produces a wrap below 0.
  function automatic logic [CNT_W-1:0] count_step(
    input logic [CNT_W-1:0] cur,
    input logic [CNT_W-1:0] rel
  );
    if (cur == '0) begin
      return rel;
    end
    return cur - CNT_W'(1);
  endfunction

  // A start from IDLE only counts when there is something to count down and
  // pause is not competing for the same edge.
  assign start_idle = (state == IDLE) && !pause && start && (out != '0);

  // The prescaler restarts on every load and on a fresh start; a resume from
  // PAUSED deliberately keeps it so the partial period carries over.
  assign pre_clr = load || start_idle;

  // Pause and load both freeze the prescaler on the edge they are sampled,
  // which keeps a pause of P cycles shifting later events by exactly P.
  assign pre_en  = (state == RUN) && !load && !pause;

  tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (pre_clr),
    .en   (pre_en),
    .num  (num),
    .tick (tick)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (load) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start_idle) begin
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (pause) begin
            state_nxt = PAUSED;
          end else if (tick && (out == CNT_W'(1)) && !auto) begin
            state_nxt = IDLE;
          end
        end
        PAUSED: begin
          if (!pause && start) begin
            state_nxt = RUN;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output / datapath next values
  always_comb begin
    out_nxt    = out;
    reload_nxt = reload;
    done_nxt   = 1'b0;
    if (load) begin
      out_nxt    = load_val;
      reload_nxt = load_val;
    end else if (tick) begin
      // tick is only ever high in RUN with no pause or load competing.
      out_nxt  = count_step(out, reload);
      done_nxt = (out == CNT_W'(1));
    end
  end

  // Registered outputs; running follows the state being entered so it
  // changes on the same edge as the transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      out     <= '0;
      reload  <= '0;
      done    <= 1'b0;
      running <= 1'b0;
    end else begin
      out     <= out_nxt;
      reload  <= reload_nxt;
      done    <= done_nxt;
      running <= (state_nxt == RUN);
    end
  end

endmodule : cnt_down

// File: doc/cnt_down.md
# cnt_down

Loadable 6-bit countdown timer: the down-counting counterpart to the free-running up-counter chain (`top_cnt` / `cnt6`). A programmable prescaler divides `clk` into count ticks (`num` cycles per tick, e.g. 50 000 000 for 1 s at 50 MHz). A small run/pause state machine decrements a loaded value to zero, pulses `done`, and optionally reloads. It drives timeouts and countdown displays in the practice top levels.

## Interface
- `CNT_W`, 6, width of count value.
- `DIV_W`, 32, width of prescaler and `num`.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `num`  in  DIV_W  clk cycles per count tick; 0 and 1 both mean "tick every cycle"; sampled continuously.
- `load`  in  1  load `load_val` into counter and reload register.
- `load_val`  in  CNT_W  value to load.
- `start`  in  1  begin or resume counting.
- `pause`  in  1  suspend counting.
- `auto`  in  1  reload on expiry instead of stopping; sampled at expiry.
- `out`  out  CNT_W  current count, registered.
- `running`  out  1  high in RUN state.
- `done`  out  1  one-cycle pulse on expiry.

## Operation
- States: IDLE, RUN, PAUSED. Encoding is held in the shared package.
- Control is sampled at each rising edge with priority `rst` > `load` > `pause` > `start`.
- `rst`: state IDLE. `out`, reload register, prescaler, `running` and `done` all go to 0.
- `load` (any state):
  - `out` and reload register take `load_val`.
  - Prescaler clears; state goes to IDLE.
  - `load` during RUN aborts the count with no `done`.
- `start`:
  - IDLE with `out != 0`: go to RUN and clear the prescaler.
  - IDLE with `out == 0`: ignored; stay IDLE, no `done`.
  - PAUSED: go to RUN and keep the prescaler value, so the partial period resumes.
  - RUN: ignored.
- `pause`: RUN goes to PAUSED and the prescaler holds. Ignored in IDLE and PAUSED.
- Prescaler (RUN only):
  - Counts 0..N-1, where N = max(`num`, 1).
  - Tick is asserted in the cycle the prescaler equals N-1; the prescaler then wraps to 0.
  - If `num` is lowered below the current prescaler value, the prescaler wraps at the DIV_W boundary; no special handling.
- On tick in RUN:
  - `out > 1`: `out` decrements by 1.
  - `out == 1`: `out` goes to 0 and `done` pulses on the same edge. Then, if `auto == 0`, go to IDLE; if `auto == 1`, stay RUN.
  - `out == 0` (only reachable when `auto` = 1 after expiry): `out` takes the reload register value.
- With `auto`, one period is (reload + 1) ticks, including one tick spent at 0.
- Reload register value 0 with `auto` = 1: `out` stays 0 and `done` does not repeat.
- Arithmetic is unsigned and modulo 2^CNT_W. A decrement below 0 is never generated.

## Timing
- Reset values: `out` = 0, `running` = 0, `done` = 0.
- `out`, `running` and `done` are registered outputs with no combinational path from inputs.
- Edge numbering: `start` sampled at edge k.
  - `running` = 1 from edge k.
  - First decrement at edge k+N.
  - Subsequent decrements every N edges.
- Loaded value L with no pause:
  - `out` reaches 0 and `done` = 1 for exactly the cycle after edge k+L·N.
  - `running` falls on the same edge when `auto` = 0.
- `load` takes effect on the same edge: `out` = `load_val` the following cycle.
- Pause for P cycles delays every later event by exactly P cycles.
- Reset mid-RUN: all outputs are 0 on the next cycle, and a pending `done` is dropped.

## Structure
- Shared package `cnt_pkg` holds:
  - state localparams (IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2);
  - default widths CNT_W = 6 and DIV_W = 32.
- Sub-module `tick_gen` is the prescaler.
  - Inputs: `clk`, `rst`, `clr`, `en`, `num`.
  - Output: one-cycle `tick`.
  - Reusable by the up-counter top.
- `cnt_down` contains the FSM, the count register, the reload register and the output registers.

## Test plan
- Reset/idle: assert `rst` 2 cycles -> `out` = 0, `running` = 0, `done` = 0. `start` with `out` = 0 -> stays IDLE, no `done`.
- Basic count: `num` = 4, load 3, `start` at edge k -> `out` = 2 at k+4, 1 at k+8, 0 at k+12. `done` is a single pulse after k+12; `running` falls at k+12.
- Pause/resume: `num` = 4, load 2, `start` at k, `pause` at k+2 held 5 cycles, then `start` -> first decrement at k+4+6 (pause plus restart cycles counted), total shift equal to the paused interval.
- Auto reload: `num` = 1, load 2, `auto` = 1 -> `out` sequence 2,1,0,2,1,0… with `done` every 3 cycles; `running` stays 1.
- Priority/abort: during RUN, assert `load` (5) and `start` together -> `out` = 5, state IDLE, no `done`. Assert `rst` mid-count -> all outputs 0 next cycle.
- `num` = 0: load 4, `start` -> decrements every cycle, `done` 4 cycles after start.
